// File: rtl/vga_timing_gen_pkg.sv
`default_nettype none
// ------------------------------------------------------------------------
// vga_timing_pkg: axis phase type, 640x480@60 defaults and width helpers. Rev 1.0
// ------------------------------------------------------------------------
package vga_timing_pkg;

   typedef enum logic [1:0] {
      PH_ACTIVE = 2'd0,
      PH_FP     = 2'd1,
      PH_SYNC   = 2'd2,
      PH_BP     = 2'd3
   } phase_e;

   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;
   localparam int DEF_CLK_DIV  = 4;

   // Bits needed to hold 0..value-1; never less than one bit.
   function automatic int clog2(input int value);
      int w;
      w = 1;
      while ((1 << w) < value) begin
         w = w + 1;
      end
      return w;
   endfunction

   function automatic int max4(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

endpackage
`default_nettype wire

// File: rtl/vga_timing_gen_if.sv
`default_nettype none
// ------------------------------------------------------------------------
// vga_timing_gen_if: run control in, registered timing/position out. Rev 1.0
// ------------------------------------------------------------------------
interface vga_timing_gen_if #(
   parameter int XW = 10,
   parameter int YW = 9
);
   logic          run;
   logic          pix_ce;
   logic          hsync;
   logic          vsync;
   logic          active;
   logic          blanking;
   logic [XW-1:0] x;
   logic [YW-1:0] y;
   logic          line_start;
   logic          frame_start;

   modport master (
      input  run,
      output pix_ce, hsync, vsync, active, blanking, x, y, line_start, frame_start
   );

   modport slave (
      output run,
      input  pix_ce, hsync, vsync, active, blanking, x, y, line_start, frame_start
   );
endinterface
`default_nettype wire

// File: rtl/vga_timing_gen_axis_seq.sv
`default_nettype none
// ------------------------------------------------------------------------
// vga_axis_seq: one timing axis stepping ACTIVE->FP->SYNC->BP->ACTIVE. Rev 1.0
// ------------------------------------------------------------------------
module vga_axis_seq
   import vga_timing_pkg::*;
#(
   parameter int ACTIVE = 640,
   parameter int FP     = 16,
   parameter int SYNC   = 96,
   parameter int BP     = 48,
   parameter bit POL    = 1'b0,
   parameter int CW     = clog2(max4(ACTIVE, FP, SYNC, BP))
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          step,
   output phase_e        phase,
   output logic [CW-1:0] count,
   output logic          sync,
   output logic          wrap
);

   phase_e        phase_q, phase_d;
   logic [CW-1:0] count_q, count_d;
   logic [CW-1:0] seg_last;
   logic          last;

   always_comb begin
      seg_last = CW'(ACTIVE - 1);
      case (phase_q)
         PH_FP:   seg_last = CW'(FP - 1);
         PH_SYNC: seg_last = CW'(SYNC - 1);
         PH_BP:   seg_last = CW'(BP - 1);
         default: seg_last = CW'(ACTIVE - 1);
      endcase
   end

   assign last = (count_q == seg_last);

   always_comb begin
      phase_d = phase_q;
      count_d = count_q;
      if (step) begin
         if (last) begin
            count_d = '0;
            case (phase_q)
               PH_ACTIVE: phase_d = PH_FP;
               PH_FP:     phase_d = PH_SYNC;
               PH_SYNC:   phase_d = PH_BP;
               default:   phase_d = PH_ACTIVE;
            endcase
         end else begin
            count_d = count_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         phase_q <= PH_ACTIVE;
         count_q <= '0;
      end else begin
         phase_q <= phase_d;
         count_q <= count_d;
      end
   end

   assign phase = phase_q;
   assign count = count_q;
   assign sync  = (phase_q == PH_SYNC) ? POL : ~POL;
   // Last unit of the back porch: the next step rolls this axis over.
   assign wrap  = (phase_q == PH_BP) && last;

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ------------------------------------------------------------------------
// vga_timing_gen: parametrised VGA timing with pixel divider, run/pause, strobes. Rev 1.0
// ------------------------------------------------------------------------
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP,
   parameter bit H_POL    = 1'b0,
   parameter bit V_POL    = 1'b0,
   parameter int CLK_DIV  = DEF_CLK_DIV,
   parameter int XW       = 10,
   parameter int YW       = 9
) (
   input  logic             clk,
   input  logic             rst,
   vga_timing_gen_if.master bus
);

   localparam int            HCW      = clog2(max4(H_ACTIVE, H_FP, H_SYNC, H_BP));
   localparam int            VCW      = clog2(max4(V_ACTIVE, V_FP, V_SYNC, V_BP));
   localparam int            DW       = clog2(CLK_DIV);
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

   logic [DW-1:0]  div_q, div_d;
   logic           div_zero;
   logic           h_step, v_step;
   phase_e         h_phase, v_phase;
   logic [HCW-1:0] h_count;
   logic [VCW-1:0] v_count;
   logic           h_sync, v_sync;
   logic           h_wrap, v_wrap_unused;

   logic           active_d, line_start_d, frame_start_d;
   logic [XW-1:0]  x_d;
   logic [YW-1:0]  y_d;

   logic           pix_ce_q, hsync_q, vsync_q, active_q, blanking_q;
   logic           line_start_q, frame_start_q;
   logic [XW-1:0]  x_q;
   logic [YW-1:0]  y_q;

   assign div_zero = (div_q == '0);
   assign div_d    = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
   // The axes step on the edge ending a pixel period; the output register
   // picks up the new position one clk later, together with pix_ce.
   assign h_step   = bus.run && (div_q == DIV_LAST);
   assign v_step   = h_step && h_wrap;

   vga_axis_seq #(
      .ACTIVE (H_ACTIVE),
      .FP     (H_FP),
      .SYNC   (H_SYNC),
      .BP     (H_BP),
      .POL    (H_POL),
      .CW     (HCW)
   ) u_h_axis (
      .clk   (clk),
      .rst   (rst),
      .step  (h_step),
      .phase (h_phase),
      .count (h_count),
      .sync  (h_sync),
      .wrap  (h_wrap)
   );

   vga_axis_seq #(
      .ACTIVE (V_ACTIVE),
      .FP     (V_FP),
      .SYNC   (V_SYNC),
      .BP     (V_BP),
      .POL    (V_POL),
      .CW     (VCW)
   ) u_v_axis (
      .clk   (clk),
      .rst   (rst),
      .step  (v_step),
      .phase (v_phase),
      .count (v_count),
      .sync  (v_sync),
      .wrap  (v_wrap_unused)
   );

   always_comb begin
      active_d      = (h_phase == PH_ACTIVE) && (v_phase == PH_ACTIVE);
      x_d           = (h_phase == PH_ACTIVE) ? XW'(h_count) : '0;
      y_d           = (v_phase == PH_ACTIVE) ? YW'(v_count) : '0;
      line_start_d  = div_zero && (h_phase == PH_ACTIVE) && (h_count == '0);
      frame_start_d = line_start_d && (v_phase == PH_ACTIVE) && (v_count == '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         div_q         <= '0;
         pix_ce_q      <= 1'b0;
         hsync_q       <= ~H_POL;
         vsync_q       <= ~V_POL;
         active_q      <= 1'b0;
         blanking_q    <= 1'b1;
         x_q           <= '0;
         y_q           <= '0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else if (bus.run) begin
         div_q         <= div_d;
         pix_ce_q      <= div_zero;
         hsync_q       <= h_sync;
         vsync_q       <= v_sync;
         active_q      <= active_d;
         blanking_q    <= ~active_d;
         x_q           <= x_d;
         y_q           <= y_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
      end else begin
         pix_ce_q      <= 1'b0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end
   end

   assign bus.pix_ce      = pix_ce_q;
   assign bus.hsync       = hsync_q;
   assign bus.vsync       = vsync_q;
   assign bus.active      = active_q;
   assign bus.blanking    = blanking_q;
   assign bus.x           = x_q;
   assign bus.y           = y_q;
   assign bus.line_start  = line_start_q;
   assign bus.frame_start = frame_start_q;

endmodule
`default_nettype wire
